// File: rtl/usb_tx_phy_pkg.sv
// usb_tx_phy_pkg: shared types and constants for the full-speed USB transmit path
package usb_tx_phy_pkg;
    typedef enum logic [1:0] {SE0, J, K} line_state_t;
    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP0, EOP1, EOPJ} tx_state_t;
    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam logic [2:0] STUFF_LIMIT = 3'd6;
    function automatic line_state_t nrzi_next(input line_state_t l, input logic b);
        return b ? l : (l == J ? K : J);
    endfunction
endpackage

// File: rtl/usb_tx_bitstuff.sv
// usb_tx_bitstuff: ones counter for stuff detection, NRZI line level and D+/D- encoding
module usb_tx_bitstuff
    import usb_tx_phy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        idle,
    input  logic        bit_end,
    input  logic        bit_val,
    input  logic        load,
    input  logic        nrzi,
    input  logic        nbit,
    input  line_state_t sym,
    output logic        stuff_due,
    output logic        d_p,
    output logic        d_n
);
    logic [2:0]  ones;
    line_state_t line;

    assign stuff_due = bit_val && ones == STUFF_LIMIT - 3'd1;
    assign d_p       = line == J;
    assign d_n       = line == K;

    // Count consecutive transmitted ones and hold the line symbol for the current bit period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= '0;
            line <= J;
        end else if (clr) begin
            ones <= '0;
            line <= J;
        end else begin
            if (idle)
                ones <= '0;
            else if (bit_end)
                ones <= !bit_val ? '0 : ones == STUFF_LIMIT ? ones : ones + 3'd1;
            if (load)
                line <= nrzi ? nrzi_next(line, nbit) : sym;
        end
    end
endmodule

// File: rtl/usb_tx_phy.sv
// usb_tx_phy: full-speed USB transmit serializer with SYNC, bit stuffing, NRZI and EOP
module usb_tx_phy
    import usb_tx_phy_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       usb_reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       d_p,
    output logic       d_n,
    output logic       oe
);
    localparam int DW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t     state;
    logic [7:0]    shreg;
    logic [2:0]    idx;
    logic [DW-1:0] div;
    logic          strobe, in_bits, bit_end, cur_bit, stuff_due, fetch;
    logic          load, nrzi, nbit;
    line_state_t   sym;

    assign strobe    = div == DW'(CLKS_PER_BIT - 1);
    assign in_bits   = state == SYNC || state == DATA || state == STUFF;
    assign bit_end   = strobe && in_bits;
    assign cur_bit   = (state == SYNC || state == DATA) && shreg[0];
    assign fetch     = bit_end && !stuff_due && idx == 3'd7;
    assign tx_ready  = fetch && tx_valid && !usb_reset;
    assign tx_active = state != IDLE;
    assign oe        = tx_active;

    // Pick the symbol of the bit period that begins on the next cycle
    always_comb begin
        load = state == IDLE ? tx_valid : strobe;
        nrzi = state == IDLE || (in_bits && !(fetch && !tx_valid));
        nbit = state == IDLE ? SYNC_PATTERN[0] : stuff_due ? 1'b0 : fetch ? tx_data[0] : shreg[1];
        sym  = (state == EOP0 || (fetch && !tx_valid)) ? SE0 : J;
    end

    // Packet sequencer: bit divider, shifter, bit index and state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            div   <= '0;
        end else if (usb_reset) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            div   <= '0;
        end else begin
            div <= (state == IDLE || strobe) ? '0 : div + 1'b1;
            case (state)
                IDLE: if (tx_valid) begin
                    state <= SYNC;
                    shreg <= SYNC_PATTERN;
                    idx   <= '0;
                end
                SYNC, DATA, STUFF: if (strobe) begin
                    if (stuff_due) begin
                        state <= STUFF;
                    end else if (idx == 3'd7) begin
                        state <= tx_valid ? DATA : EOP0;
                        shreg <= tx_data;
                        idx   <= '0;
                    end else begin
                        state <= state == STUFF ? DATA : state;
                        shreg <= shreg >> 1;
                        idx   <= idx + 3'd1;
                    end
                end
                EOP0: if (strobe) state <= EOP1;
                EOP1: if (strobe) state <= EOPJ;
                default: if (strobe) state <= IDLE;
            endcase
        end
    end

    usb_tx_bitstuff u_bitstuff (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (usb_reset),
        .idle      (state == IDLE),
        .bit_end   (bit_end),
        .bit_val   (cur_bit),
        .load      (load),
        .nrzi      (nrzi),
        .nbit      (nbit),
        .sym       (sym),
        .stuff_due (stuff_due),
        .d_p       (d_p),
        .d_n       (d_n)
    );
endmodule

// File: tb/tb_usb_tx_phy.sv
// tb_usb_tx_phy: directed checks of the USB transmit serializer line output and handshake
module tb_usb_tx_phy;
    logic       clk = 0, rst_n = 0, usb_reset = 0, sel = 0;
    logic       v2 = 0, v4 = 0;
    logic [7:0] d2 = 0, d4 = 0;
    logic       rdy2, act2, dp2, dn2, oe2, rdy4, act4, dp4, dn4, oe4;
    logic       s_rdy, s_act, s_dp, s_dn, s_oe;
    int         checks = 0, failures = 0;
    logic [7:0] pkt [4];
    logic [7:0] line_q [$];
    int         rq [$];
    int         er [$];

    always #5 clk = ~clk;

    assign s_rdy = sel ? rdy4 : rdy2;
    assign s_act = sel ? act4 : act2;
    assign s_dp  = sel ? dp4 : dp2;
    assign s_dn  = sel ? dn4 : dn2;
    assign s_oe  = sel ? oe4 : oe2;

    usb_tx_phy #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .usb_reset(usb_reset), .tx_data(d2), .tx_valid(v2),
        .tx_ready(rdy2), .tx_active(act2), .d_p(dp2), .d_n(dn2), .oe(oe2)
    );

    usb_tx_phy #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .usb_reset(1'b0), .tx_data(d4), .tx_valid(v4),
        .tx_ready(rdy4), .tx_active(act4), .d_p(dp4), .d_n(dn4), .oe(oe4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if (sel) begin
            v4 = v;
            d4 = d;
        end else begin
            v2 = v;
            d2 = d;
        end
    endtask

    task automatic run(input string tag, input int n, input int cpb, input string exp, input int nrdy);
        int   bi = 0, act = 0, p;
        bit   started = 0, done = 0;
        logic r;
        line_q.delete();
        rq.delete();
        @(posedge clk); #1;
        drive(1'b1, pkt[0]);
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            r = s_rdy;
            if (s_oe) begin
                started = 1;
                line_q.push_back(s_dp && !s_dn ? "J" : !s_dp && s_dn ? "K" : !s_dp && !s_dn ? "0" : "X");
                if (r) rq.push_back(line_q.size() - 1);
                if (s_act) act++;
            end else if (started) begin
                done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
                if (n == 0) drive(1'b0, 8'h00);
                else if (r) begin
                    bi++;
                    drive(bi < n, pkt[bi & 3]);
                end
            end
        end
        drive(1'b0, 8'h00);
        check({tag, "_done"}, done, 1);
        check({tag, "_len"}, line_q.size(), exp.len() * cpb);
        check({tag, "_active"}, act, exp.len() * cpb);
        check({tag, "_nrdy"}, rq.size(), nrdy);
        foreach (er[i]) check($sformatf("%s_rdy%0d", tag, i), i < rq.size() ? rq[i] : -1, er[i]);
        for (int k = 0; k < exp.len(); k++)
            for (int c = 0; c < cpb; c++) begin
                p = k * cpb + c;
                check($sformatf("%s_b%0d", tag, k), p < line_q.size() ? line_q[p] : 8'h3F, exp[k]);
            end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_oe", oe2, 0);
        check("rst_dp", dp2, 1);
        check("rst_dn", dn2, 0);
        check("rst_active", act2, 0);
        check("rst_ready", rdy2, 0);
        check("rst_oe4", oe4, 0);
        check("rst_dp4", dp4, 1);
        rst_n = 1;

        pkt[0] = 8'hD2;
        er = '{15};
        run("ack", 1, 2, "KJKJKJKKJJKJJKKK00J", 1);

        pkt[0] = 8'hC3; pkt[1] = 8'hFF; pkt[2] = 8'hFF;
        er = '{15, 31, 49};
        run("data0", 3, 2, {"KJKJKJKK", "KKJKJKKK", "KKKKJJJJJ", "JJKKKKKKKJ", "00J"}, 3);

        pkt[0] = 8'h55; pkt[1] = 8'hAA; pkt[2] = 8'h0F; pkt[3] = 8'h3C;
        er = '{15, 31, 47, 63};
        run("stream", 4, 2, {"KJKJKJKK", "KJJKKJJK", "JJKKJJKK", "KKKKJKJK", "JKKKKKJK", "00J"}, 4);

        pkt[0] = 8'h00;
        er = {};
        run("empty", 0, 2, "KJKJKJKK00J", 0);

        @(posedge clk); #1;
        v2 = 1; d2 = 8'h55;
        repeat (37) @(posedge clk);
        #1;
        check("ur_mid_oe", oe2, 1);
        usb_reset = 1; v2 = 0;
        @(negedge clk);
        check("ur_ready", rdy2, 0);
        @(posedge clk); #1;
        usb_reset = 0;
        @(negedge clk);
        check("ur_oe", oe2, 0);
        check("ur_dp", dp2, 1);
        check("ur_dn", dn2, 0);
        check("ur_active", act2, 0);
        pkt[0] = 8'hD2;
        er = '{15};
        run("ur_ack", 1, 2, "KJKJKJKKJJKJJKKK00J", 1);

        @(posedge clk); #1;
        v2 = 1; d2 = 8'h55;
        repeat (21) @(posedge clk);
        #3;
        rst_n = 0; v2 = 0;
        #1;
        check("rn_oe", oe2, 0);
        check("rn_dp", dp2, 1);
        check("rn_dn", dn2, 0);
        check("rn_active", act2, 0);
        @(posedge clk); #1;
        rst_n = 1;
        run("rn_ack", 1, 2, "KJKJKJKKJJKJJKKK00J", 1);

        sel = 1;
        er = '{31};
        run("ack4", 1, 4, "KJKJKJKKJJKJJKKK00J", 1);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
